// File: rtl/id_hazard_forward_pkg.sv
// ============================================================================
// id_hazard_forward_pkg : shared types and encodings for ID-stage forwarding
// Revision: 1.0
// ============================================================================
`default_nettype none

package id_hazard_forward_pkg;

    localparam int REG_AW_MAX = 16;
    localparam int FWD_RF     = 0;

    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // The rd field is sized for the widest register file; narrower files zero-extend.
    typedef struct packed {
        logic                  v;
        logic [REG_AW_MAX-1:0] rd;
        logic                  wr;
        logic                  ld;
    } shadow_entry_t;

endpackage

`default_nettype wire

// File: rtl/id_hazard_forward_fwd_match_prio.sv
// ============================================================================
// fwd_match_prio : one ID operand against all in-flight writers, youngest wins
// Revision: 1.0
// ============================================================================
`default_nettype none

module fwd_match_prio
    import id_hazard_forward_pkg::*;
#(
    parameter  int REG_AW   = 5,
    parameter  int DEPTH    = 3,
    parameter  int LOAD_RDY = 2,
    localparam int SELW     = sel_w(DEPTH)
) (
    input  logic                      id_valid,
    input  logic [REG_AW-1:0]         src,
    input  logic                      src_used,
    input  shadow_entry_t [DEPTH-1:0] entries,
    output logic [SELW-1:0]           sel,
    output logic                      stall_req
);

    // Scan oldest to youngest so the youngest match overwrites the result.
    always_comb begin
        sel       = SELW'(FWD_RF);
        stall_req = 1'b0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (id_valid && src_used && entries[s].v && entries[s].wr &&
                (entries[s].rd == REG_AW_MAX'(src)) && (src != '0)) begin
                if (!entries[s].ld || (s >= LOAD_RDY)) begin
                    sel       = SELW'(s + 1);
                    stall_req = 1'b0;
                end else begin
                    sel       = SELW'(FWD_RF);
                    stall_req = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/id_hazard_forward.sv
// ============================================================================
// id_hazard_forward : ID-stage forward select, load-use stall and stall counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_hazard_forward
    import id_hazard_forward_pkg::*;
#(
    parameter  int REG_AW   = 5,
    parameter  int NSRC     = 2,
    parameter  int DEPTH    = 3,
    parameter  int LOAD_RDY = 2,
    parameter  int CNT_W    = 16,
    localparam int SELW     = sel_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [NSRC*REG_AW-1:0] id_src,
    input  logic [NSRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_is_load,
    input  logic                   hold,
    input  logic                   flush,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic                   stall,
    output logic                   issue,
    output logic [CNT_W-1:0]       stall_count
);

    shadow_entry_t [DEPTH-1:0] entries_q;
    shadow_entry_t [DEPTH-1:0] entries_d;
    logic [CNT_W-1:0]          stall_count_q;
    logic [CNT_W-1:0]          stall_count_d;

    logic [NSRC*SELW-1:0]      w_sel;
    logic [NSRC-1:0]           w_stall_req;
    logic                      w_stall;
    logic                      w_issue;
    shadow_entry_t             w_new_entry;

    genvar i;
    generate
        for (i = 0; i < NSRC; i++) begin : g_src
            fwd_match_prio #(
                .REG_AW   (REG_AW),
                .DEPTH    (DEPTH),
                .LOAD_RDY (LOAD_RDY)
            ) u_match (
                .id_valid  (id_valid),
                .src       (id_src[i*REG_AW +: REG_AW]),
                .src_used  (id_src_used[i]),
                .entries   (entries_q),
                .sel       (w_sel[i*SELW +: SELW]),
                .stall_req (w_stall_req[i])
            );
        end
    endgenerate

    assign w_stall = |w_stall_req;
    assign w_issue = id_valid & ~w_stall & ~hold & ~flush;

    assign fwd_sel     = rst_n ? w_sel : '0;
    assign stall       = rst_n & w_stall;
    assign issue       = rst_n & w_issue;
    assign stall_count = stall_count_q;

    always_comb begin
        w_new_entry    = '0;
        w_new_entry.v  = 1'b1;
        w_new_entry.rd = REG_AW_MAX'(id_rd);
        w_new_entry.wr = id_regwrite;
        w_new_entry.ld = id_is_load;
    end

    // Shadow pipeline advances with the real one; a stalled or killed ID slot becomes a bubble.
    always_comb begin
        entries_d     = entries_q;
        stall_count_d = stall_count_q;
        if (!hold) begin
            for (int s = DEPTH - 1; s >= 1; s--) begin
                entries_d[s] = entries_q[s-1];
            end
            entries_d[0] = w_issue ? w_new_entry : '0;
            if (w_stall && (stall_count_q != '1)) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entries_q     <= '0;
            stall_count_q <= '0;
        end else begin
            entries_q     <= entries_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_hazard_forward.sv
// ============================================================================
// tb_id_hazard_forward : directed self-checking bench for id_hazard_forward
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_id_hazard_forward;

    localparam int REG_AW   = 5;
    localparam int NSRC     = 2;
    localparam int DEPTH    = 3;
    localparam int LOAD_RDY = 2;
    localparam int CNT_W    = 4;
    localparam int SELW     = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   id_valid;
    logic [NSRC*REG_AW-1:0] id_src;
    logic [NSRC-1:0]        id_src_used;
    logic [REG_AW-1:0]      id_rd;
    logic                   id_regwrite;
    logic                   id_is_load;
    logic                   hold;
    logic                   flush;
    logic [NSRC*SELW-1:0]   fwd_sel;
    logic                   stall;
    logic                   issue;
    logic [CNT_W-1:0]       stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_hazard_forward #(
        .REG_AW   (REG_AW),
        .NSRC     (NSRC),
        .DEPTH    (DEPTH),
        .LOAD_RDY (LOAD_RDY),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_is_load  (id_is_load),
        .hold        (hold),
        .flush       (flush),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .issue       (issue),
        .stall_count (stall_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] s1, input logic [4:0] s0,
                          input logic [1:0] used, input logic [4:0] rd,
                          input logic wr, input logic ld);
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_rd       = rd;
        id_regwrite = wr;
        id_is_load  = ld;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic clear_pipe();
        for (int k = 0; k < DEPTH; k++) begin
            nop();
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        set_id(1'b1, 5'd8, 5'd8, 2'b11, 5'd8, 1'b1, 1'b0);
        tick();
        tick();
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_issue", 32'(issue), 32'd0);
        check_eq("rst_fwd", 32'(fwd_sel), 32'd0);
        check_eq("rst_count", 32'(stall_count), 32'd0);

        rst_n = 1'b1;
        set_id(1'b1, 5'd8, 5'd8, 2'b11, 5'd0, 1'b0, 1'b0);
        check_eq("empty_fwd", 32'(fwd_sel), 32'd0);
        check_eq("empty_stall", 32'(stall), 32'd0);
        tick();

        // ALU result of r8 consumed after 0..3 intervening nops
        for (int gap = 0; gap < 4; gap++) begin
            set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 1'b0);
            tick();
            for (int k = 0; k < gap; k++) begin
                nop();
                tick();
            end
            set_id(1'b1, 5'd0, 5'd8, 2'b01, 5'd0, 1'b0, 1'b0);
            check_eq($sformatf("alu_fwd_gap%0d", gap), 32'(fwd_sel),
                     (gap < 3) ? 32'(gap + 1) : 32'd0);
            check_eq($sformatf("alu_stall_gap%0d", gap), 32'(stall), 32'd0);
            check_eq($sformatf("alu_issue_gap%0d", gap), 32'(issue), 32'd1);
            tick();
        end

        // load-use: lw r9 then beq r9,r9
        clear_pipe();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd9, 5'd9, 2'b11, 5'd0, 1'b0, 1'b0);
        check_eq("lu_stall0", 32'(stall), 32'd1);
        check_eq("lu_issue0", 32'(issue), 32'd0);
        check_eq("lu_fwd0", 32'(fwd_sel), 32'd0);
        tick();
        check_eq("lu_stall1", 32'(stall), 32'd1);
        check_eq("lu_issue1", 32'(issue), 32'd0);
        tick();
        check_eq("lu_stall2", 32'(stall), 32'd0);
        check_eq("lu_fwd2", 32'(fwd_sel), 32'hF);
        check_eq("lu_issue2", 32'(issue), 32'd1);
        check_eq("lu_count", 32'(stall_count), 32'd2);
        tick();

        // youngest writer of r5 wins
        clear_pipe();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd5, 2'b11, 5'd0, 1'b0, 1'b0);
        check_eq("prio_fwd", 32'(fwd_sel), 32'h5);
        tick();

        // a load writing r0 is never a hazard
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0);
        check_eq("r0_fwd", 32'(fwd_sel), 32'd0);
        check_eq("r0_stall", 32'(stall), 32'd0);
        tick();

        // hold for 3 cycles in the middle of a load-use stall
        clear_pipe();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd9, 5'd0, 2'b10, 5'd0, 1'b0, 1'b0);
        hold = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("hold_stall%0d", k), 32'(stall), 32'd1);
            check_eq($sformatf("hold_issue%0d", k), 32'(issue), 32'd0);
            tick();
            check_eq($sformatf("hold_count%0d", k), 32'(stall_count), 32'd2);
        end
        hold = 1'b0;
        #1;
        check_eq("unhold_stall0", 32'(stall), 32'd1);
        tick();
        check_eq("unhold_count0", 32'(stall_count), 32'd3);
        check_eq("unhold_stall1", 32'(stall), 32'd1);
        tick();
        check_eq("unhold_count1", 32'(stall_count), 32'd4);
        check_eq("unhold_fwd", 32'(fwd_sel), 32'hC);
        check_eq("unhold_issue", 32'(issue), 32'd1);
        tick();

        // flush kills the writer of r8
        clear_pipe();
        flush = 1'b1;
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 1'b0);
        check_eq("flush_issue", 32'(issue), 32'd0);
        tick();
        flush = 1'b0;
        set_id(1'b1, 5'd0, 5'd8, 2'b01, 5'd0, 1'b0, 1'b0);
        check_eq("flush_fwd", 32'(fwd_sel), 32'd0);
        check_eq("flush_stall", 32'(stall), 32'd0);
        tick();

        // flush during a stall still counts as a stall cycle
        clear_pipe();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1);
        tick();
        flush = 1'b1;
        set_id(1'b1, 5'd0, 5'd9, 2'b01, 5'd0, 1'b0, 1'b0);
        check_eq("flush_stall_stall", 32'(stall), 32'd1);
        check_eq("flush_stall_issue", 32'(issue), 32'd0);
        tick();
        flush = 1'b0;
        check_eq("flush_stall_count", 32'(stall_count), 32'd5);
        clear_pipe();

        // saturation: 20 stall cycles into a 4-bit counter
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int it = 1; it <= 10; it++) begin
            set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1);
            tick();
            set_id(1'b1, 5'd0, 5'd9, 2'b01, 5'd0, 1'b0, 1'b0);
            tick();
            tick();
            tick();
            if (it == 7)  check_eq("sat_count14", 32'(stall_count), 32'd14);
            if (it == 8)  check_eq("sat_count15", 32'(stall_count), 32'd15);
        end
        check_eq("sat_count_final", 32'(stall_count), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
